// File: rtl/tpu_mmu_2x2.sv
// tpu_mmu_2x2: weight-stationary 2x2 signed int8 systolic matrix-multiply unit.
// Each accepted activation row a produces c[j] = a[0]*W[0][j] + a[1]*W[1][j]
// exactly three edges after acceptance. A job is N_ROWS rows and starts on one
// start pulse.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; weight writes are honoured here only
// ST_FEED  | a_ready=1; rows are accepted and counted up to N_ROWS
// ST_DRAIN | all rows accepted; waits for the last result (done), then idle
module tpu_mmu_2x2 #(
   parameter int N_ROWS = 2,
   parameter int ACC_W  = 18
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               w_we,
   input  logic [1:0]         w_addr,
   input  logic [7:0]         w_data,
   input  logic               start,
   input  logic               a_valid,
   output logic               a_ready,
   input  logic [15:0]        a_row,
   output logic               c_valid,
   output logic [2*ACC_W-1:0] c_row,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN} state_t;

   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0][7:0] w_q, w_d;
   logic a_ready_q, a_ready_d;
   logic busy_q, busy_d;

   // Stage 1: row 0 of the array sees a[0]; a[1] waits one cycle (input skew).
   logic [7:0] a0_q, a0_d, a1_sk_q, a1_sk_d;
   logic v1_q, v1_d, l1_q, l1_d;
   // Stage 2: row-0 PE products are registered; a[1] reaches array row 1.
   logic [15:0] p00_q, p00_d, p01_q, p01_d;
   logic [7:0] a1_q, a1_d;
   logic v2_q, v2_d, l2_q, l2_d;
   // Stage 3: row-1 PEs add their products into the column partial sums.
   logic [16:0] s0_q, s0_d, s1_q, s1_d;
   logic v3_q, v3_d, l3_q, l3_d;
   // Output registers: both columns leave together (column 1 deskewed).
   logic [2*ACC_W-1:0] c_row_q, c_row_d;
   logic c_valid_q, c_valid_d, done_q, done_d;

   logic accept, last_row;
   logic [15:0] m10, m11;
   logic signed [16:0] s0_s, s1_s;

   // Sign-extended 16x16 multiply: the low 16 bits equal the signed 8x8 product.
   function automatic logic [15:0] smul8(input logic [7:0] x, input logic [7:0] y);
      logic [15:0] xe, ye;
      xe = {{8{x[7]}}, x};
      ye = {{8{y[7]}}, y};
      return xe * ye;
   endfunction

   // Next-state logic for the FSM, weight file, row counter and datapath pipeline.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      w_d       = w_q;
      accept    = a_ready_q && a_valid;
      last_row  = (cnt_q == 8'(N_ROWS - 1));

      if (state_q == ST_IDLE && w_we) begin
         w_d[w_addr] = w_data;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FEED;
         end
         ST_FEED: begin
            if (accept) begin
               if (last_row) begin
                  state_d = ST_DRAIN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ST_DRAIN: begin
            if (done_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      a_ready_d = (state_d == ST_FEED);
      busy_d    = (state_d != ST_IDLE);

      a0_d    = accept ? a_row[7:0]  : a0_q;
      a1_sk_d = accept ? a_row[15:8] : a1_sk_q;
      v1_d    = accept;
      l1_d    = accept && last_row;

      p00_d = v1_q ? smul8(a0_q, w_q[0]) : p00_q;
      p01_d = v1_q ? smul8(a0_q, w_q[1]) : p01_q;
      a1_d  = v1_q ? a1_sk_q : a1_q;
      v2_d  = v1_q;
      l2_d  = l1_q;

      m10  = smul8(a1_q, w_q[2]);
      m11  = smul8(a1_q, w_q[3]);
      s0_d = v2_q ? ({p00_q[15], p00_q} + {m10[15], m10}) : s0_q;
      s1_d = v2_q ? ({p01_q[15], p01_q} + {m11[15], m11}) : s1_q;
      v3_d = v2_q;
      l3_d = l2_q;

      s0_s      = s0_q;
      s1_s      = s1_q;
      c_row_d   = v3_q ? {ACC_W'(s1_s), ACC_W'(s0_s)} : c_row_q;
      c_valid_d = v3_q;
      done_d    = v3_q && l3_q;
   end

   // All state registers; reset aborts any job and clears the weights.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         w_q       <= '0;
         a_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         a0_q      <= '0;
         a1_sk_q   <= '0;
         v1_q      <= 1'b0;
         l1_q      <= 1'b0;
         p00_q     <= '0;
         p01_q     <= '0;
         a1_q      <= '0;
         v2_q      <= 1'b0;
         l2_q      <= 1'b0;
         s0_q      <= '0;
         s1_q      <= '0;
         v3_q      <= 1'b0;
         l3_q      <= 1'b0;
         c_row_q   <= '0;
         c_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         w_q       <= w_d;
         a_ready_q <= a_ready_d;
         busy_q    <= busy_d;
         a0_q      <= a0_d;
         a1_sk_q   <= a1_sk_d;
         v1_q      <= v1_d;
         l1_q      <= l1_d;
         p00_q     <= p00_d;
         p01_q     <= p01_d;
         a1_q      <= a1_d;
         v2_q      <= v2_d;
         l2_q      <= l2_d;
         s0_q      <= s0_d;
         s1_q      <= s1_d;
         v3_q      <= v3_d;
         l3_q      <= l3_d;
         c_row_q   <= c_row_d;
         c_valid_q <= c_valid_d;
         done_q    <= done_d;
      end
   end

   assign a_ready = a_ready_q;
   assign busy    = busy_q;
   assign c_valid = c_valid_q;
   assign c_row   = c_row_q;
   assign done    = done_q;

endmodule

// File: tb/tb_tpu_mmu_2x2.sv
// Bench for tpu_mmu_2x2: scoreboard of expected result rows, filled on row
// acceptance and drained by a negedge monitor that also checks latency.
module tb_tpu_mmu_2x2;

   localparam int N_ROWS = 2;
   localparam int ACC_W  = 18;

   logic clk_sys = 1'b0;
   logic rst_n;
   logic w_we;
   logic [1:0] w_addr;
   logic [7:0] w_data;
   logic start;
   logic a_valid;
   logic a_ready;
   logic [15:0] a_row;
   logic c_valid;
   logic [2*ACC_W-1:0] c_row;
   logic busy;
   logic done;

   tpu_mmu_2x2 #(.N_ROWS(N_ROWS), .ACC_W(ACC_W)) dut (
      .clk     (clk_sys),
      .rst_n   (rst_n),
      .w_we    (w_we),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .start   (start),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a_row   (a_row),
      .c_valid (c_valid),
      .c_row   (c_row),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [2*ACC_W-1:0] row;
      logic               last;
      int                 cyc;
   } exp_t;

   exp_t sb[$];
   int   mw[4];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   rows = 0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [2*ACC_W-1:0] model_row(input int a0, input int a1);
      int c0, c1;
      logic [ACC_W-1:0] e0, e1;
      c0 = a0 * mw[0] + a1 * mw[2];
      c1 = a0 * mw[1] + a1 * mw[3];
      e0 = ACC_W'(c0);
      e1 = ACC_W'(c1);
      return {e1, e0};
   endfunction

   // Result monitor: pop and compare every c_valid, flag anything unexpected.
   always @(negedge clk_sys) begin
      if (rst_n) begin
         if (c_valid) begin
            if (sb.size() == 0) begin
               check("c_valid_stray", 64'(c_valid), 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("c_row", 64'(c_row), 64'(e.row));
               check("done", 64'(done), 64'(e.last));
               check("latency", 64'(cyc), 64'(e.cyc + 3));
            end
         end else if (done) begin
            check("done_stray", 64'(done), 64'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic write_w(input int addr, input int val, input bit track);
      w_we = 1'b1;
      w_addr = 2'(addr);
      w_data = 8'(val);
      step();
      w_we = 1'b0;
      if (track) mw[addr] = val;
   endtask

   task automatic start_job();
      start = 1'b1;
      step();
      start = 1'b0;
      rows = 0;
      check("busy_after_start", 64'(busy), 64'd1);
      check("ready_after_start", 64'(a_ready), 64'd1);
   endtask

   task automatic send_row(input int a0, input int a1);
      int t;
      a_valid = 1'b1;
      a_row = {8'(a1), 8'(a0)};
      t = 0;
      while (!a_ready && t < 20) begin
         step();
         t++;
      end
      if (!a_ready) begin
         check("ready_timeout", 64'(a_ready), 64'd1);
         a_valid = 1'b0;
      end else begin
         exp_t e;
         step();
         rows++;
         e.row = model_row(a0, a1);
         e.last = (rows == N_ROWS);
         e.cyc = cyc;
         sb.push_back(e);
         if (rows == N_ROWS) rows = 0;
         a_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy || sb.size() != 0) && t < 40) begin
         step();
         t++;
      end
      check("idle_timeout", 64'(busy || sb.size() != 0), 64'd0);
   endtask

   task automatic wait_done_busy();
      int t;
      t = 0;
      @(negedge clk_sys);
      while (!done && t < 20) begin
         @(negedge clk_sys);
         t++;
      end
      check("done_seen", 64'(done), 64'd1);
      check("busy_at_done", 64'(busy), 64'd1);
      @(negedge clk_sys);
      check("busy_after_done", 64'(busy), 64'd0);
      check("ready_after_done", 64'(a_ready), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      w_we = 1'b0;
      w_addr = '0;
      w_data = '0;
      start = 1'b0;
      a_valid = 1'b0;
      a_row = '0;
      for (int i = 0; i < 4; i++) mw[i] = 0;
      repeat (3) @(posedge clk_sys);
      #1;
      check("rst_a_ready", 64'(a_ready), 64'd0);
      check("rst_c_valid", 64'(c_valid), 64'd0);
      check("rst_c_row", 64'(c_row), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      step();

      // Basic product
      write_w(0, 1, 1'b1);
      write_w(1, 2, 1'b1);
      write_w(2, 3, 1'b1);
      write_w(3, 4, 1'b1);
      start_job();
      send_row(5, 6);
      send_row(-3, 7);
      wait_idle();

      // Back-to-back rows; busy falls one cycle after done
      start_job();
      a_valid = 1'b1;
      send_row(1, 0);
      send_row(0, 1);
      wait_done_busy();
      wait_idle();

      // Extremes
      for (int i = 0; i < 4; i++) write_w(i, -128, 1'b1);
      start_job();
      send_row(-128, -128);
      send_row(127, -128);
      wait_idle();
      write_w(0, 127, 1'b1);
      write_w(1, 127, 1'b1);
      start_job();
      send_row(127, -128);
      send_row(-128, 127);
      wait_idle();

      // Gap in FEED, plus dropped weight write and ignored start mid-job
      write_w(0, 1, 1'b1);
      write_w(1, 2, 1'b1);
      write_w(2, 3, 1'b1);
      write_w(3, 4, 1'b1);
      start_job();
      send_row(2, 3);
      write_w(0, 100, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      send_row(-4, 9);
      wait_idle();
      repeat (3) step();
      check("start_ignored_busy", 64'(busy), 64'd0);

      // a_valid while IDLE has no effect
      a_valid = 1'b1;
      a_row = 16'h0505;
      repeat (4) step();
      check("idle_valid_ready", 64'(a_ready), 64'd0);
      check("idle_valid_busy", 64'(busy), 64'd0);
      a_valid = 1'b0;
      start_job();
      send_row(10, -10);
      send_row(1, 1);
      wait_idle();

      // Reset mid-job
      start_job();
      send_row(9, 9);
      step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_c_valid", 64'(c_valid), 64'd0);
      check("mid_rst_c_row", 64'(c_row), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_ready", 64'(a_ready), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      sb.delete();
      rows = 0;
      for (int i = 0; i < 4; i++) mw[i] = 0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      start_job();
      send_row(3, 4);
      send_row(-5, 6);
      wait_idle();

      // Same-cycle weight write and start
      w_we = 1'b1;
      w_addr = 2'd3;
      w_data = 8'd7;
      mw[3] = 7;
      start_job();
      w_we = 1'b0;
      send_row(0, 1);
      send_row(2, 2);
      wait_idle();

      repeat (5) step();
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
